// File: rtl/cp0_pkg.sv
// Shared constants for the second-generation CP0: register addresses,
// exception codes and SR/Cause field positions.
package cp0_pkg;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   localparam int unsigned SR_IE     = 0;
   localparam int unsigned SR_EXL    = 1;
   localparam int unsigned IM_LO     = 10;
   localparam int unsigned IM_HI     = 15;
   localparam int unsigned CAUSE_BD  = 31;
   localparam int unsigned CAUSE_TI  = 30;
   localparam int unsigned EXC_LO    = 2;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with power-of-two prescaler and sticky match flag.
import cp0_pkg::*;

module cp0_timer #(
   parameter int unsigned CNT_DIV_LOG2 = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        cmp_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam logic [3:0] PRESC_MAX = 4'((32'd1 << CNT_DIV_LOG2) - 32'd1);

   logic [3:0]  presc;
   logic        tick;
   logic [31:0] count_inc;

   assign tick      = (presc == PRESC_MAX);
   assign count_inc = count + 32'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc   <= '0;
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         if (count_we) begin
            count <= wdata;
            presc <= '0;
         end else begin
            presc <= tick ? '0 : presc + 4'd1;
            if (tick)
               count <= count_inc;
         end
         // Compare write wins over a match; a written Count never matches.
         if (cmp_we) begin
            compare <= wdata;
            ti      <= 1'b0;
         end else if (!count_we && tick && (count_inc == compare)) begin
            ti <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_gen2.sv
// Coprocessor 0: interrupt/exception arbitration, SR/Cause/EPC/BadVAddr,
// optional Count/Compare timer and read-only PRId.
import cp0_pkg::*;

module cp0_gen2 #(
   parameter int unsigned NUM_HWINT    = 6,
   parameter int unsigned TIMER_EN     = 1,
   parameter int unsigned CNT_DIV_LOG2 = 0,
   parameter logic [31:0] PRID         = 32'h0000_4D50
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [4:0]           CP0Add,
   input  logic [31:0]          CP0In,
   output logic [31:0]          CP0Out,
   input  logic [31:0]          VPC,
   input  logic                 BDIn,
   input  logic [4:0]           ExcCodeIn,
   input  logic [31:0]          BadVAddrIn,
   input  logic [NUM_HWINT-1:0] HWInt,
   input  logic                 EXLClr,
   output logic [31:0]          EPCOut,
   output logic                 Req,
   output logic                 TimerIrq
);

   logic [31:0] epc;
   logic [31:0] badvaddr;
   logic [5:0]  im;
   logic [5:0]  ip;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [4:0]  exccode;

   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   logic [5:0]  hw;
   logic        int_req;
   logic        exc_req;
   logic [31:0] next_epc;

   always_comb begin
      hw = '0;
      hw[NUM_HWINT-1:0] = HWInt;
      if (TIMER_EN != 0)
         hw[5] = hw[5] | ti;
   end

   assign int_req  = ie & ~exl & (|(hw & im));
   assign exc_req  = ~exl & (ExcCodeIn != 5'd0);
   assign Req      = int_req | exc_req;
   assign next_epc = Req ? (BDIn ? VPC - 32'd4 : VPC) : epc;
   assign EPCOut   = next_epc;
   assign TimerIrq = ti;

   generate
      if (TIMER_EN != 0) begin : g_timer
         cp0_timer #(
            .CNT_DIV_LOG2(CNT_DIV_LOG2)
         ) u_timer (
            .clk      (clk),
            .reset    (reset),
            .count_we (~Req & en & (CP0Add == REG_COUNT)),
            .cmp_we   (~Req & en & (CP0Add == REG_COMPARE)),
            .wdata    (CP0In),
            .count    (count),
            .compare  (compare),
            .ti       (ti)
         );
      end else begin : g_no_timer
         assign count   = '0;
         assign compare = '0;
         assign ti      = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         epc      <= '0;
         badvaddr <= '0;
         im       <= '0;
         ip       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         exccode  <= '0;
      end else begin
         ip <= hw;
         if (Req) begin
            exl     <= 1'b1;
            epc     <= next_epc;
            bd      <= BDIn;
            exccode <= int_req ? EXC_INT : ExcCodeIn;
            if (!int_req && (ExcCodeIn == EXC_ADEL || ExcCodeIn == EXC_ADES))
               badvaddr <= BadVAddrIn;
         end else begin
            // A same-cycle SR write overrides eret's EXL clear.
            if (EXLClr)
               exl <= 1'b0;
            if (en) begin
               case (CP0Add)
                  REG_SR: begin
                     im  <= CP0In[IM_HI:IM_LO];
                     exl <= CP0In[SR_EXL];
                     ie  <= CP0In[SR_IE];
                  end
                  REG_EPC: epc <= CP0In;
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      CP0Out = '0;
      case (CP0Add)
         REG_BADVADDR: CP0Out = badvaddr;
         REG_COUNT:    CP0Out = count;
         REG_COMPARE:  CP0Out = compare;
         REG_SR:       CP0Out = {16'b0, im, 8'b0, exl, ie};
         REG_CAUSE:    CP0Out = {bd, ti, 14'b0, ip, 3'b0, exccode, 2'b0};
         REG_EPC:      CP0Out = EPCOut;
         REG_PRID:     CP0Out = PRID;
         default:      CP0Out = '0;
      endcase
   end

endmodule
